// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory initiator: size codes,
// FSM states, byte-lane masks and the request legality check.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  // Unsigned sizes exist only for loads; halfwords need even, words 4-byte alignment.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// according to the load size code.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_initiator.sv
// Single-port data-memory initiator: turns one CPU load/store request into a
// registered memory access with alignment checks, lane steering and timeout.
//   state     | meaning
//   ST_IDLE   | ready for a request
//   ST_ACCESS | strobe held, waiting for mem_resp or timeout
//   ST_RESP   | one-cycle response to the CPU
module dmem_initiator
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] load_data;
  logic [3:0]  store_mask;

  dmem_load_align u_load_align (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .rdata_i  (mem_rdata),
    .data_o   (load_data)
  );

  always_comb begin
    case (req_funct3)
      F3_B:    store_mask = LANE_B << req_addr[1:0];
      F3_H:    store_mask = LANE_H << req_addr[1:0];
      default: store_mask = LANE_W;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          rdata_d  = 32'd0;
          if (!access_legal(req_we, req_funct3, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d       = 1'b0;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_read_d  = ~req_we;
            mem_write_d = req_we;
            mem_wmask_d = req_we ? store_mask : 4'b0000;
            if (!req_we)
              mem_wdata_d = 32'd0;
            else if (req_funct3 == F3_W)
              mem_wdata_d = req_wdata;
            else
              mem_wdata_d = req_wdata << {req_addr[1:0], 3'b000};
            cnt_d   = CW'(TIMEOUT_CYCLES - 1);
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // A response arriving on the terminal cycle still wins over the timeout.
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b0;
          rdata_d     = we_q ? 32'd0 : load_data;
          state_d     = ST_RESP;
        end else if (cnt_q == '0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          rdata_d     = 32'd0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        err_d   = 1'b0;
        rdata_d = 32'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_addr_q  <= 32'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wmask_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_initiator.md
DMEM_INITIATOR -- requirements
Module: dmem_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of ACCESS cycles without mem_resp before the access is aborted with an error.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  CPU-side request valid.
REQ-005 SHALL have port req_ready  out  1  accepting requests; high only in IDLE, decoded from the state register only.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle response pulse.
REQ-011 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have port rsp_err  out  1  misaligned access, illegal funct3 or timeout; qualified by rsp_valid.
REQ-013 SHALL have ports mem_addr out 32, mem_read out 1, mem_write out 1, mem_wmask out 4, mem_wdata out 32, mem_rdata in 32, mem_resp in 1; these form the initiator side of the single-port memory interface.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, plus IDLE -> RESP for rejected requests.
REQ-015 SHALL accept a request on a rising edge with req_valid && req_ready and capture req_we, req_funct3, req_addr and req_wdata.
REQ-016 SHALL reject, without any memory access, a request that is a halfword with addr[0]=1, a word with addr[1:0]!=0, an illegal funct3, or a store with funct3 BU/HU; next state RESP with rsp_err=1.
REQ-017 SHALL drive all mem_* outputs from registers and hold them stable for the whole ACCESS state; mem_read/mem_write SHALL never be high together.
REQ-018 SHALL drive mem_addr = {addr[31:2], 2'b00}.
REQ-019 SHALL drive mem_wmask for stores as B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111; loads 4'b0000.
REQ-020 SHALL drive mem_wdata as req_wdata shifted left by 8*addr[1:0] for B/H, unshifted for W, and 0 for loads.
REQ-021 SHALL sample mem_resp only in ACCESS; on mem_resp=1 it SHALL deassert mem_read/mem_write, register the extended data and enter RESP.
REQ-022 SHALL select the lane of mem_rdata indexed by addr[1:0] for loads, sign-extending for B/H and zero-extending for BU/HU; W SHALL pass through unchanged.
REQ-023 SHALL count ACCESS cycles, and on reaching TIMEOUT_CYCLES without mem_resp SHALL deassert the memory strobes and enter RESP with rsp_err=1.
REQ-024 SHALL give mem_resp priority when mem_resp and timeout occur in the same cycle.
REQ-025 SHALL assert rsp_valid for exactly one cycle (the RESP state), then return to IDLE; the earliest next acceptance SHALL be the edge ending the first IDLE cycle.
REQ-026 SHALL have latency with a one-cycle responder of: acceptance at edge E0, strobe high after E0, mem_resp sampled at E2, rsp_valid high E2..E3.
REQ-027 SHALL ignore a stale mem_resp outside ACCESS.

Reset
REQ-028 SHALL on rst_n=0, immediately and regardless of state, enter IDLE and drive req_ready=1 after release; rsp_valid, rsp_err, mem_read, mem_write = 0; mem_addr, mem_wdata, rsp_rdata = 0; mem_wmask = 0; timeout counter = 0.
REQ-029 SHALL abandon an in-flight access on reset mid-ACCESS and produce no response for it.

Structure
REQ-030 SHALL place the funct3 size enum, the FSM state enum and the byte-lane constants in the shared package dmem_pkg.
REQ-031 SHALL put the load lane-select/extension logic in one sub-module, dmem_load_align (combinational); everything else SHALL be in dmem_initiator.

Verification
REQ-032 SHALL cover: SW addr 0x1000_0004, wdata 0xDEADBEEF -> mem_write, mem_wmask 1111, mem_addr 0x1000_0004; rsp_valid 1, rsp_err 0, rsp_rdata 0.
REQ-033 SHALL cover: LB addr 0x1000_0003 with mem_rdata 0x80FF_0000 -> rsp_rdata 0xFFFFFF80; the same with LBU -> 0x00000080.
REQ-034 SHALL cover: SH addr 0x2002, wdata 0x0000_ABCD -> mem_wmask 1100, mem_wdata 0xABCD_0000, mem_addr 0x2000.
REQ-035 SHALL cover: LW addr 0x3001 -> mem_read never high; rsp_valid one cycle after acceptance with rsp_err 1.
REQ-036 SHALL cover: responder silent with TIMEOUT_CYCLES=8 -> mem_read high exactly 8 cycles, then rsp_err 1; in a separate run mem_resp and timeout coincide -> rsp_err 0.
REQ-037 SHALL cover: rst_n low during ACCESS -> mem_read low asynchronously, no rsp_valid, req_ready high after release; back-to-back loads match the REQ-026 latency.
